// File: rtl/c499_sec_encoder_if.sv
// Streaming interface of the c499 SEC encoder.
//   in_valid/in_ready/in_data : data-word input handshake
//   inj_arm/inj_pos           : fault-injection request, sampled with an input word
//   out_valid/out_ready       : codeword output handshake
//   out_data/out_chk/out_cen  : codeword data bits, check bits c0..c7, check-enable
//   out_injected              : presented codeword carries an injected fault
// master = the side that supplies words and sinks codewords; slave = the encoder.
interface c499_sec_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        inj_arm;
  logic [5:0]  inj_pos;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [7:0]  out_chk;
  logic        out_cen;
  logic        out_injected;

  modport master (
    output in_valid, in_data, inj_arm, inj_pos, out_ready,
    input  in_ready, out_valid, out_data, out_chk, out_cen, out_injected
  );

  modport slave (
    input  in_valid, in_data, inj_arm, inj_pos, out_ready,
    output in_ready, out_valid, out_data, out_chk, out_cen, out_injected
  );
endinterface

// File: rtl/c499_sec_encoder.sv
// c499_sec_encoder: two-stage streaming SEC encoder for the c499 checker.
// A 32-bit word is extended with 8 check bits so that the c499 syndrome is
// zero; one codeword bit may optionally be flipped for decoder testing.
// Ports:
//   CK       : clock, rising edge
//   RN       : asynchronous active-low reset
//   bus      : c499_sec_encoder_if.slave (input word, injection, codeword out)
//   word_cnt : codewords delivered, modulo 2^CNT_W
module c499_sec_encoder #(
  parameter int CNT_W          = 16,
  parameter int INJ_EN_DEFAULT = 0
) (
  input  logic             CK,
  input  logic             RN,
  c499_sec_encoder_if.slave bus,
  output logic [CNT_W-1:0] word_cnt
);

  logic        vld_p1;
  logic        vld_p2;
  logic        ld_p1;
  logic        ld_p2;
  logic        acc_p0;

  logic [31:0] data_p1;
  logic [7:0]  colp_p1;
  logic [7:0]  grpp_p1;
  logic        inj_p1;
  logic [5:0]  pos_p1;

  logic [39:0] cw_p2;
  logic        inj_p2;

  // Column parities: bits k, k+4, k+8, k+12 of the low half (k=0..3) and
  // the same columns of the high half (k=4..7).
  function automatic logic [7:0] col_par(input logic [31:0] d);
    logic [7:0] c;
    c = '0;
    for (int k = 0; k < 4; k++) begin
      c[k]   = d[k]      ^ d[k+4]  ^ d[k+8]  ^ d[k+12];
      c[k+4] = d[k+16]   ^ d[k+20] ^ d[k+24] ^ d[k+28];
    end
    return c;
  endfunction

  // Nibble parities: g[i] = parity of d[4i+3:4i].
  function automatic logic [7:0] grp_par(input logic [31:0] d);
    logic [7:0] g;
    g = '0;
    for (int i = 0; i < 8; i++) begin
      g[i] = ^d[4*i +: 4];
    end
    return g;
  endfunction

  // Each check bit is one column parity plus the two nibbles of the
  // opposite half that the c499 parity tree folds into it.
  function automatic logic [7:0] chk_bits(input logic [7:0] col, input logic [7:0] g);
    logic [7:0] c;
    c[0] = col[0] ^ g[4] ^ g[5];
    c[1] = col[1] ^ g[6] ^ g[7];
    c[2] = col[2] ^ g[4] ^ g[6];
    c[3] = col[3] ^ g[5] ^ g[7];
    c[4] = col[4] ^ g[0] ^ g[1];
    c[5] = col[5] ^ g[2] ^ g[3];
    c[6] = col[6] ^ g[0] ^ g[2];
    c[7] = col[7] ^ g[1] ^ g[3];
    return c;
  endfunction

  // Flip codeword bit pos when en; en is only set for pos < 40.
  function automatic logic [39:0] inject(input logic [39:0] cw, input logic en,
                                         input logic [5:0] pos);
    logic [39:0] m;
    m = en ? (40'd1 << pos) : 40'd0;
    return cw ^ m;
  endfunction

  assign ld_p2        = !vld_p2 || bus.out_ready;
  assign ld_p1        = !vld_p1 || ld_p2;
  assign acc_p0       = bus.in_valid && ld_p1;
  assign bus.in_ready = ld_p1;

  // ---- stage 0 -> stage 1: parity pre-reduction ----
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      vld_p1 <= 1'b0;
      inj_p1 <= 1'(INJ_EN_DEFAULT);
    end else if (ld_p1) begin
      vld_p1 <= bus.in_valid;
      if (bus.in_valid) begin
        inj_p1 <= bus.inj_arm && (bus.inj_pos < 6'd40);
      end
    end
  end

  always_ff @(posedge CK) begin
    if (acc_p0) begin
      data_p1 <= bus.in_data;
      colp_p1 <= col_par(bus.in_data);
      grpp_p1 <= grp_par(bus.in_data);
      pos_p1  <= bus.inj_pos;
    end
  end

  // ---- stage 1 -> stage 2: check bits and fault injection ----
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      vld_p2 <= 1'b0;
      cw_p2  <= '0;
      inj_p2 <= 1'b0;
    end else if (ld_p2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        cw_p2  <= inject({chk_bits(colp_p1, grpp_p1), data_p1}, inj_p1, pos_p1);
        inj_p2 <= inj_p1;
      end
    end
  end

  // ---- stage 2 -> sink: delivered-word counter ----
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      word_cnt <= '0;
    end else if (vld_p2 && bus.out_ready) begin
      word_cnt <= word_cnt + CNT_W'(1);
    end
  end

  assign bus.out_valid    = vld_p2;
  assign bus.out_cen      = vld_p2;
  assign bus.out_data     = cw_p2[31:0];
  assign bus.out_chk      = cw_p2[39:32];
  assign bus.out_injected = inj_p2;

endmodule

// File: tb/tb_c499_sec_encoder.sv
// Testbench for c499_sec_encoder: directed vectors with literal expectations
// plus a per-cycle scoreboard built from the check-bit masks and a c499-style
// syndrome corrector.
module tb_c499_sec_encoder;

  logic        CK;
  logic        RN;
  logic [15:0] word_cnt;

  c499_sec_encoder_if bus ();

  c499_sec_encoder #(.CNT_W(16), .INJ_EN_DEFAULT(0)) dut (
    .CK       (CK),
    .RN       (RN),
    .bus      (bus),
    .word_cnt (word_cnt)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  int errors = 0;
  int checks = 0;

  // Data bits covered by each check bit c0..c7.
  localparam logic [31:0] MASK [8] = '{
    32'h00FF1111, 32'hFF002222, 32'h0F0F4444, 32'hF0F08888,
    32'h111100FF, 32'h2222FF00, 32'h44440F0F, 32'h8888F0F0
  };

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_chk(input logic [31:0] d);
    logic [7:0] c;
    for (int i = 0; i < 8; i++) c[i] = ^(d & MASK[i]);
    return c;
  endfunction

  function automatic logic [7:0] h_col(input int k);
    logic [7:0]  col;
    logic [31:0] m;
    for (int i = 0; i < 8; i++) begin
      m      = MASK[i];
      col[i] = m[k];
    end
    return col;
  endfunction

  function automatic logic [7:0] syndrome(input logic [31:0] d, input logic [7:0] c);
    return ref_chk(d) ^ c;
  endfunction

  // Single-error correction as the c499 does it: a data bit whose H column
  // equals the syndrome is inverted.
  function automatic logic [31:0] c499_correct(input logic [31:0] d, input logic [7:0] c);
    logic [7:0]  syn;
    logic [31:0] r;
    syn = syndrome(d, c);
    r   = d;
    for (int k = 0; k < 32; k++)
      if (syn != 8'h00 && h_col(k) == syn) r[k] = ~r[k];
    return r;
  endfunction

  typedef struct {
    logic [31:0] d;
    logic [39:0] cw;
    logic        inj;
    int          acc;
  } ent_t;

  ent_t        q[$];
  int          cyc = 0;
  int          cnt_m = 0;
  logic        stall_prev = 1'b0;
  logic [40:0] held;

  // Scoreboard: compare at the falling edge, then predict what the next
  // rising edge will transfer.
  always @(negedge CK) begin
    ent_t        e;
    logic        exp_vld;
    logic [31:0] fixed;
    if (!RN) begin
      q.delete();
      cnt_m      = 0;
      stall_prev = 1'b0;
    end else begin
      exp_vld = (q.size() > 0) && (cyc - q[0].acc >= 2);
      check("out_valid", 64'(bus.out_valid), 64'(exp_vld));
      check("out_cen", 64'(bus.out_cen), 64'(bus.out_valid));
      check("word_cnt", 64'(word_cnt), 64'(cnt_m[15:0]));
      check("in_ready", 64'(bus.in_ready), 64'((q.size() < 2) || bus.out_ready));
      if (stall_prev)
        check("stall_hold", 64'({bus.out_injected, bus.out_chk, bus.out_data}), 64'(held));
      if (bus.out_valid && q.size() > 0) begin
        e = q[0];
        check("out_data", 64'(bus.out_data), 64'(e.cw[31:0]));
        check("out_chk", 64'(bus.out_chk), 64'(e.cw[39:32]));
        check("out_injected", 64'(bus.out_injected), 64'(e.inj));
        if (!e.inj) check("c499_syndrome", 64'(syndrome(bus.out_data, bus.out_chk)), 64'd0);
        fixed = c499_correct(bus.out_data, bus.out_chk);
        check("c499_corrected", 64'(fixed), 64'(e.d));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() > 0) void'(q.pop_front());
        cnt_m = (cnt_m + 1) % 65536;
      end
      if (bus.in_valid && bus.in_ready) begin
        e.d   = bus.in_data;
        e.cw  = {ref_chk(bus.in_data), bus.in_data};
        e.inj = bus.inj_arm && (bus.inj_pos < 6'd40);
        if (e.inj) e.cw[bus.inj_pos] = ~e.cw[bus.inj_pos];
        e.acc = cyc;
        q.push_back(e);
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      held       = {bus.out_injected, bus.out_chk, bus.out_data};
      cyc++;
    end
  end

  task automatic send(input logic [31:0] d, input logic arm, input logic [5:0] pos);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.inj_arm  = arm;
    bus.inj_pos  = pos;
    @(negedge CK);
    while (!bus.in_ready && n < 200) begin
      @(negedge CK);
      n++;
    end
    if (n >= 200) check("send_timeout", 64'(n), 64'd0);
    @(posedge CK);
    #1;
    bus.in_valid = 1'b0;
    bus.inj_arm  = 1'b0;
  endtask

  task automatic tick;
    @(posedge CK);
    #1;
  endtask

  logic [7:0] exp_seq [4];
  logic       rnd_done;

  initial begin
    RN            = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.inj_arm   = 1'b0;
    bus.inj_pos   = '0;
    bus.out_ready = 1'b0;
    #12;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_cen", 64'(bus.out_cen), 64'd0);
    check("rst_out_data", 64'(bus.out_data), 64'd0);
    check("rst_out_chk", 64'(bus.out_chk), 64'd0);
    check("rst_out_injected", 64'(bus.out_injected), 64'd0);
    check("rst_word_cnt", 64'(word_cnt), 64'd0);
    @(negedge CK);
    #2 RN = 1'b1;
    tick();
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Single word, two-cycle latency.
    bus.out_ready = 1'b1;
    send(32'h00000001, 1'b0, 6'd0);
    check("t1_not_yet", 64'(bus.out_valid), 64'd0);
    tick();
    check("t1_valid", 64'(bus.out_valid), 64'd1);
    check("t1_data", 64'(bus.out_data), 64'h00000001);
    check("t1_chk", 64'(bus.out_chk), 64'h51);
    check("t1_cen", 64'(bus.out_cen), 64'd1);
    check("t1_cnt0", 64'(word_cnt), 64'd0);
    tick();
    check("t1_cnt1", 64'(word_cnt), 64'd1);

    // Back-to-back words at full throughput.
    exp_seq = '{8'h15, 8'h8A, 8'h00, 8'h00};
    fork
      begin
        send(32'h00010000, 1'b0, 6'd0);
        send(32'h80000000, 1'b0, 6'd0);
        send(32'hFFFFFFFF, 1'b0, 6'd0);
        send(32'h00000000, 1'b0, 6'd0);
      end
      begin
        int n;
        n = 0;
        @(negedge CK);
        while (!bus.out_valid && n < 20) begin
          @(negedge CK);
          n++;
        end
        for (int i = 0; i < 4; i++) begin
          check("t2_valid", 64'(bus.out_valid), 64'd1);
          check("t2_chk", 64'(bus.out_chk), 64'(exp_seq[i]));
          check("t2_in_ready", 64'(bus.in_ready), 64'd1);
          @(negedge CK);
        end
      end
    join
    tick();
    tick();
    check("t2_cnt", 64'(word_cnt), 64'd5);

    // Stall with both stages full.
    bus.out_ready = 1'b0;
    send(32'h12345678, 1'b0, 6'd0);
    send(32'hCAFEF00D, 1'b0, 6'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge CK);
      check("t3_in_ready", 64'(bus.in_ready), 64'd0);
      check("t3_valid", 64'(bus.out_valid), 64'd1);
      check("t3_data", 64'(bus.out_data), 64'h12345678);
      check("t3_cnt", 64'(word_cnt), 64'd5);
    end
    tick();
    bus.out_ready = 1'b1;
    tick();
    check("t3_rel_cnt1", 64'(word_cnt), 64'd6);
    check("t3_rel_data", 64'(bus.out_data), 64'hCAFEF00D);
    tick();
    check("t3_rel_cnt2", 64'(word_cnt), 64'd7);
    check("t3_rel_empty", 64'(bus.out_valid), 64'd0);

    // Fault injection.
    send(32'h00000001, 1'b1, 6'd5);
    tick();
    check("t4_p5_data", 64'(bus.out_data), 64'h00000021);
    check("t4_p5_chk", 64'(bus.out_chk), 64'h51);
    check("t4_p5_inj", 64'(bus.out_injected), 64'd1);
    send(32'h00000001, 1'b1, 6'd33);
    tick();
    check("t4_p33_data", 64'(bus.out_data), 64'h00000001);
    check("t4_p33_chk", 64'(bus.out_chk), 64'h53);
    check("t4_p33_inj", 64'(bus.out_injected), 64'd1);
    send(32'h00000001, 1'b1, 6'd50);
    tick();
    check("t4_p50_data", 64'(bus.out_data), 64'h00000001);
    check("t4_p50_chk", 64'(bus.out_chk), 64'h51);
    check("t4_p50_inj", 64'(bus.out_injected), 64'd0);
    tick();
    check("t4_cnt", 64'(word_cnt), 64'd10);

    // Asynchronous reset with both stages full.
    bus.out_ready = 1'b0;
    send(32'h11111111, 1'b0, 6'd0);
    send(32'h22222222, 1'b0, 6'd0);
    #3 RN = 1'b0;
    #1;
    check("t5_valid", 64'(bus.out_valid), 64'd0);
    check("t5_cen", 64'(bus.out_cen), 64'd0);
    check("t5_cnt", 64'(word_cnt), 64'd0);
    check("t5_data", 64'(bus.out_data), 64'd0);
    check("t5_chk", 64'(bus.out_chk), 64'd0);
    check("t5_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge CK);
    @(negedge CK);
    #2 RN = 1'b1;
    tick();
    bus.out_ready = 1'b1;
    check("t5_no_stale", 64'(bus.out_valid), 64'd0);
    send(32'h0BADBEEF, 1'b0, 6'd0);
    check("t5_no_stale2", 64'(bus.out_valid), 64'd0);
    tick();
    check("t5_first_data", 64'(bus.out_data), 64'h0BADBEEF);
    check("t5_first_valid", 64'(bus.out_valid), 64'd1);
    tick();
    check("t5_first_cnt", 64'(word_cnt), 64'd1);

    // Every injection position once.
    for (int p = 0; p < 40; p++) send($urandom, 1'b1, 6'(p));

    // Random traffic with random back-pressure.
    rnd_done = 1'b0;
    fork
      begin
        while (!rnd_done) begin
          tick();
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
      begin
        for (int i = 0; i < 10000; i++)
          send($urandom, ($urandom_range(0, 3) == 0), 6'($urandom_range(0, 63)));
        rnd_done = 1'b1;
      end
    join
    bus.out_ready = 1'b1;
    repeat (6) tick();
    check("drain_empty", 64'(q.size()), 64'd0);
    check("final_cnt", 64'(word_cnt), 64'd10041);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
